// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: fetch PC, IF/ID and ID/EX, with stall/flush/redirect handling.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall and bubble counters.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              PCSrcD,
  input  logic              JumpD,
  input  logic [31:0]       PCBranchD,
  input  logic [31:0]       PCJumpD,
  input  logic [31:0]       InstrF,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       SignImmD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       SignImmE,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic              ValidE
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       BubbleCnt
`endif
);

  function automatic logic [31:0] pcInc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [31:0]       pcF_p0;
  logic [31:0]       instrD_p1;
  logic [31:0]       pcPlus4D_p1;
  logic              vld_p1;
  logic [CTRL_W-1:0] ctrlE_p2;
  logic [31:0]       rd1E_p2;
  logic [31:0]       rd2E_p2;
  logic [31:0]       signImmE_p2;
  logic [4:0]        rsE_p2;
  logic [4:0]        rtE_p2;
  logic [4:0]        rdE_p2;
  logic              vld_p2;

  logic redirectD;
  assign redirectD = PCSrcD | JumpD;

  // Fetch stage: PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      pcF_p0 <= RESET_PC;
    end else if (!StallF) begin
      pcF_p0 <= JumpD ? PCJumpD : (PCSrcD ? PCBranchD : pcInc(pcF_p0));
    end
  end

  // IF/ID boundary: a stall outranks the squash so a stalled branch is not lost
  always_ff @(posedge clk) begin
    if (reset) begin
      instrD_p1   <= '0;
      pcPlus4D_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (StallD) begin
      instrD_p1   <= instrD_p1;
      pcPlus4D_p1 <= pcPlus4D_p1;
      vld_p1      <= vld_p1;
    end else if (redirectD) begin
      instrD_p1   <= '0;
      pcPlus4D_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      instrD_p1   <= InstrF;
      pcPlus4D_p1 <= pcInc(pcF_p0);
      vld_p1      <= 1'b1;
    end
  end

  // ID/EX boundary: flush inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrlE_p2    <= '0;
      rd1E_p2     <= '0;
      rd2E_p2     <= '0;
      signImmE_p2 <= '0;
      rsE_p2      <= '0;
      rtE_p2      <= '0;
      rdE_p2      <= '0;
      vld_p2      <= 1'b0;
    end else begin
      ctrlE_p2    <= CtrlD;
      rd1E_p2     <= RD1D;
      rd2E_p2     <= RD2D;
      signImmE_p2 <= SignImmD;
      rsE_p2      <= RsD;
      rtE_p2      <= RtD;
      rdE_p2      <= RdD;
      vld_p2      <= vld_p1;
    end
  end

  assign PCF      = pcF_p0;
  assign InstrD   = instrD_p1;
  assign PCPlus4D = pcPlus4D_p1;
  assign ValidD   = vld_p1;
  assign CtrlE    = ctrlE_p2;
  assign RD1E     = rd1E_p2;
  assign RD2E     = rd2E_p2;
  assign SignImmE = signImmE_p2;
  assign RsE      = rsE_p2;
  assign RtE      = rtE_p2;
  assign RdE      = rdE_p2;
  assign ValidE   = vld_p2;

`ifdef PIPE_PERF_CNT_EN
  logic squashD;
  logic bubbleEv;
  assign squashD  = !StallD && redirectD;
  // A flush and a squash in the same cycle are one bubble event
  assign bubbleEv = FlushE | squashD;

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (StallD)   StallCnt  <= satInc(StallCnt);
      if (bubbleEv) BubbleCnt <= satInc(BubbleCnt);
    end
  end
`endif

endmodule
